// File: rtl/doorlock_ctrl_if.sv
// Keypad/door bus of the door-lock controller. The keypad side (master) drives the keys and
// the digit shift-register taps. The controller (slave) drives the door, alarm and status lines.
interface doorlock_ctrl_if;
  // Keys are plain levels with no valid/ready pairing. The controller acts once per rising edge
  // of each level, one cycle after the rise, and ignores how long the key is held.
  logic       key_any;
  logic       enter;
  logic       change;
  logic [3:0] dig3;
  logic [3:0] dig2;
  logic [3:0] dig1;
  logic [3:0] dig0;
  logic       unlock;
  logic       alarm;
  logic       clr_entry;
  logic [2:0] digit_cnt;
  logic [1:0] fail_cnt;
  logic [1:0] state_dbg;

  modport master (
    output key_any, enter, change, dig3, dig2, dig1, dig0,
    input  unlock, alarm, clr_entry, digit_cnt, fail_cnt, state_dbg
  );

  modport slave (
    input  key_any, enter, change, dig3, dig2, dig1, dig0,
    output unlock, alarm, clr_entry, digit_cnt, fail_cnt, state_dbg
  );
endinterface

// File: rtl/doorlock_ctrl.sv
// Four-digit keypad door lock: password check, timed unlock, password change and
// a timed alarm lockout after repeated failures.
module doorlock_ctrl #(
  parameter logic [15:0] DEFAULT_PW  = 16'h1234,
  parameter logic [23:0] OPEN_CYCLES = 24'd100,
  parameter logic [23:0] LOCK_CYCLES = 24'd200,
  parameter logic [1:0]  MAX_FAIL    = 2'd3
) (
  input  logic           clk,
  input  logic           rst,
  doorlock_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OPEN  = 2'd1,
    S_SET   = 2'd2,
    S_ALARM = 2'd3
  } state_t;

  state_t      state_q;
  logic [2:0]  keys_q;      // {change, enter, key_any} registered once
  logic [2:0]  keys_prev_q; // previous value of keys_q
  logic        armed_q;     // low only on the first cycle after reset
  logic        unlock_q;
  logic        alarm_q;
  logic        clr_entry_q;
  logic [2:0]  digit_cnt_q;
  logic [1:0]  fail_cnt_q;
  logic [23:0] timer_q;
  logic [15:0] pw_q;

  logic [2:0]  digit_inc_d;
  logic [1:0]  fail_inc_d;
  logic [2:0]  keys_now;
  logic        key_edge;
  logic        enter_edge;
  logic        change_edge;
  logic [15:0] entry;

  assign keys_now    = {bus.change, bus.enter, bus.key_any};
  assign key_edge    = keys_q[0] & ~keys_prev_q[0];
  assign enter_edge  = keys_q[1] & ~keys_prev_q[1];
  assign change_edge = keys_q[2] & ~keys_prev_q[2];
  assign entry       = {bus.dig3, bus.dig2, bus.dig1, bus.dig0};

  always_comb begin
    digit_inc_d = (digit_cnt_q == 3'd4) ? 3'd4 : digit_cnt_q + 3'd1;
    fail_inc_d  = fail_cnt_q + 2'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      keys_q      <= 3'b000;
      keys_prev_q <= 3'b000;
      armed_q     <= 1'b0;
      unlock_q    <= 1'b0;
      alarm_q     <= 1'b0;
      clr_entry_q <= 1'b0;
      digit_cnt_q <= 3'd0;
      fail_cnt_q  <= 2'd0;
      timer_q     <= 24'd0;
      pw_q        <= DEFAULT_PW;
    end else begin
      keys_q      <= keys_now;
      // On the first cycle both stages load the live keys, so a key held through reset never looks like a rise.
      keys_prev_q <= armed_q ? keys_q : keys_now;
      armed_q     <= 1'b1;
      clr_entry_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (enter_edge) begin
            clr_entry_q <= 1'b1;
            digit_cnt_q <= 3'd0;
            if (digit_cnt_q == 3'd4 && entry == pw_q) begin
              state_q    <= S_OPEN;
              unlock_q   <= 1'b1;
              timer_q    <= OPEN_CYCLES - 24'd1;
              fail_cnt_q <= 2'd0;
            end else begin
              fail_cnt_q <= fail_inc_d;
              if (fail_inc_d == MAX_FAIL) begin
                state_q <= S_ALARM;
                alarm_q <= 1'b1;
                timer_q <= LOCK_CYCLES - 24'd1;
              end
            end
          end else if (key_edge) begin
            digit_cnt_q <= digit_inc_d;
          end
        end

        S_OPEN: begin
          digit_cnt_q <= 3'd0;
          // Relock beats change, which beats the hold timer running out.
          if (enter_edge) begin
            state_q  <= S_IDLE;
            unlock_q <= 1'b0;
            timer_q  <= 24'd0;
          end else if (change_edge) begin
            state_q     <= S_SET;
            unlock_q    <= 1'b0;
            clr_entry_q <= 1'b1;
            timer_q     <= 24'd0;
          end else if (timer_q == 24'd0) begin
            state_q  <= S_IDLE;
            unlock_q <= 1'b0;
          end else begin
            timer_q <= timer_q - 24'd1;
          end
        end

        S_SET: begin
          if (enter_edge) begin
            if (digit_cnt_q == 3'd4) begin
              pw_q <= entry;
            end
            state_q     <= S_IDLE;
            clr_entry_q <= 1'b1;
            digit_cnt_q <= 3'd0;
          end else if (key_edge) begin
            digit_cnt_q <= digit_inc_d;
          end
        end

        S_ALARM: begin
          digit_cnt_q <= 3'd0;
          if (timer_q == 24'd0) begin
            state_q    <= S_IDLE;
            alarm_q    <= 1'b0;
            fail_cnt_q <= 2'd0;
          end else begin
            timer_q <= timer_q - 24'd1;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.unlock    = unlock_q;
  assign bus.alarm     = alarm_q;
  assign bus.clr_entry = clr_entry_q;
  assign bus.digit_cnt = digit_cnt_q;
  assign bus.fail_cnt  = fail_cnt_q;
  assign bus.state_dbg = state_q;

endmodule
